axicb_decerr_slv: RTL
=====================

# axicb_decerr_slv

Default responder placed behind the crossbar's decode-error route: it is the end that answers misrouted AXI4 transactions that the master-side completion tracker expects to come back. It accepts write and read requests that matched no slave address range, discards write data, and returns AXI-compliant DECERR completions that carry the original ID. For reads it returns exactly ALEN+1 beats with a correct RLAST. Completions are returned in request arrival order, separately per direction.

## Interface

Parameters:
- AXI_ID_W, 8, ID width in bits
- AXI_DATA_W, 32, read data width in bits
- OSTD_NUM, 4, outstanding requests buffered per direction; power of two, ≥2

Ports:
- aclk  in  1  clock, all logic on rising edge
- arst  in  1  reset, asynchronous, active-high
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awid  in  AXI_ID_W  write ID
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wlast  in  1  last write beat
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bid  out  AXI_ID_W  write response ID
- bresp  out  2  write response, always 2'b11
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- arid  in  AXI_ID_W  read ID
- arlen  in  8  burst length minus one
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rid  out  AXI_ID_W  read ID
- rdata  out  AXI_DATA_W  always zero
- rresp  out  2  always 2'b11
- rlast  out  1  last read beat

## Operation

- Write address FIFO, depth OSTD_NUM, width AXI_ID_W. Push on awvalid&awready. awready = !aw_full, with no dependency on the pop in the same cycle.
- Write FSM has three states:
  - W_IDLE → W_DATA when the AW FIFO is non-empty.
  - W_DATA: wready=1; on wvalid&wlast go to W_RESP. Non-last beats are discarded.
  - W_RESP: bvalid=1, bid = FIFO head; on bready pop the FIFO and go to W_IDLE.
- wready is 0 outside W_DATA. W data is never accepted before its AW.
- Read address FIFO, depth OSTD_NUM, width AXI_ID_W+8 ({arlen,arid}). arready = !ar_full.
- Read FSM has two states:
  - R_IDLE → R_DATA when the AR FIFO is non-empty; clear the 8-bit beat counter.
  - R_DATA: rvalid=1, rid and rlast are taken from the FIFO head. rlast = (cnt == len).
  - On rvalid&rready&!rlast, cnt+1. On rvalid&rready&rlast, pop the FIFO and go to R_IDLE.
- The counter never wraps. The maximum len of 255 gives 256 beats and the final count of 255 asserts rlast.
- Read and write paths are fully independent and may be active in the same cycle.
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bid=0, rid=0, rdata=0, bresp=2'b11, rresp=2'b11. Both FSMs are IDLE and both FIFOs are empty.

## Timing

- AW handshake in cycle c → wready high from cycle c+2 (FIFO non-empty after c, FSM enters W_DATA at the end of c+1).
- wlast handshake in cycle c → bvalid high in cycle c+1.
- B handshake in cycle c → W_IDLE in c+1. The next write's wready rises in c+2 at the earliest.
- AR handshake in cycle c → first rvalid in cycle c+2.
- Back-to-back bursts: one idle cycle (rvalid=0) between the last beat of one burst and the first beat of the next.
- Sustained rate inside a read burst is one beat per cycle while rready=1.
- rvalid, rid and rlast are held stable while rready=0. bvalid and bid are held stable while bready=0.
- FIFO full: awready/arready drop in the cycle after the push that fills the FIFO. They rise in the cycle after the pop.
- arst asserted at any time, including mid-burst: all outputs go immediately (asynchronously) to their reset values and queued entries are lost. No completion is generated for requests that were in flight.

## Test plan

- Write burst: awid=0x05, 4 W beats with wlast on the 4th, bready=1 → wready for exactly 4 beats, then one bvalid with bid=0x05 and bresp=2'b11.
- Read burst: arid=0x0A, arlen=3, rready=1 → rvalid from 2 cycles after the AR handshake. Expect 4 consecutive beats, rid=0x0A, rdata=0, rresp=2'b11, rlast only on beat 4.
- Read length corners:
  - arlen=0 → a single beat with rlast=1.
  - arlen=255 → 256 beats with rlast only on the 256th.
- FIFO full, OSTD_NUM=4: issue 4 ARs with rready=0 → arready=0 after the 4th, rvalid held with rid of the first AR. Release rready → all 4 bursts return in order with a one-cycle gap between them, and arready returns after the first burst's last beat.
- Backpressure and concurrency:
  - Toggle rready randomly during arlen=7 → each beat is held stable until accepted, 8 beats total.
  - Concurrent write with bready=0 for 10 cycles → bvalid and bid held, read path unaffected.
- Reset mid-burst: assert arst after beat 2 of an arlen=5 read → rvalid drops immediately. After release, awready=arready=1 and no residual beats appear.

Source files
------------

// File: rtl/axicb_decerr_slv.sv
// Decode-error responder for the crossbar: swallows misrouted AXI4 requests and
// answers each one with a DECERR completion carrying its ID, in arrival order per direction.

module axicb_decerr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // The extra pointer MSB tells full from empty when the indices coincide.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
endmodule

module axicb_decerr_slv #(
    parameter int AXI_ID_W   = 8,
    parameter int AXI_DATA_W = 32,
    parameter int OSTD_NUM   = 4
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_ID_W-1:0]   awid,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [AXI_ID_W-1:0]   bid,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [AXI_ID_W-1:0]   arid,
    input  logic [7:0]            arlen,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [AXI_ID_W-1:0]   rid,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                  aw_push, aw_pop, aw_full, aw_empty;
    logic [AXI_ID_W-1:0]   aw_head;
    logic                  ar_push, ar_pop, ar_full, ar_empty;
    logic [AXI_ID_W+7:0]   ar_head;
    logic [7:0]            head_len;
    logic [AXI_ID_W-1:0]   head_id;
    logic [7:0]            cnt;

    assign awready = !aw_full;
    assign arready = !ar_full;
    assign aw_push = awvalid && awready;
    assign ar_push = arvalid && arready;
    assign head_len = ar_head[AXI_ID_W +: 8];
    assign head_id  = ar_head[AXI_ID_W-1:0];
    assign bresp = 2'b11;
    assign rresp = 2'b11;
    assign rdata = '0;

    axicb_decerr_fifo #(.WIDTH(AXI_ID_W), .DEPTH(OSTD_NUM)) u_aw_fifo (
        .aclk(aclk), .arst(arst), .push(aw_push), .din(awid),
        .pop(aw_pop), .dout(aw_head), .full(aw_full), .empty(aw_empty)
    );

    axicb_decerr_fifo #(.WIDTH(AXI_ID_W + 8), .DEPTH(OSTD_NUM)) u_ar_fifo (
        .aclk(aclk), .arst(arst), .push(ar_push), .din({arlen, arid}),
        .pop(ar_pop), .dout(ar_head), .full(ar_full), .empty(ar_empty)
    );

    // Write path: W data is only taken once its AW sits at the FIFO head.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) w_state <= W_IDLE;
        else      w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (!aw_empty)       w_next = W_DATA;
            W_DATA:  if (wvalid && wlast) w_next = W_RESP;
            W_RESP:  if (bready)          w_next = W_IDLE;
            default:                      w_next = W_IDLE;
        endcase
    end

    always_comb begin
        wready = 1'b0;
        bvalid = 1'b0;
        bid    = '0;
        aw_pop = 1'b0;
        case (w_state)
            W_DATA: wready = 1'b1;
            W_RESP: begin
                bvalid = 1'b1;
                bid    = aw_head;
                aw_pop = bready;
            end
            default: ;
        endcase
    end

    // Read path: one burst at a time, the head entry is retired on its last beat.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) r_state <= R_IDLE;
        else      r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (!ar_empty)                 r_next = R_DATA;
            R_DATA:  if (rvalid && rready && rlast) r_next = R_IDLE;
            default:                                r_next = R_IDLE;
        endcase
    end

    always_comb begin
        rvalid = 1'b0;
        rid    = '0;
        rlast  = 1'b0;
        ar_pop = 1'b0;
        if (r_state == R_DATA) begin
            rvalid = 1'b1;
            rid    = head_id;
            rlast  = (cnt == head_len);
            ar_pop = rready && rlast;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst)
            cnt <= '0;
        else if (r_state == R_IDLE && !ar_empty)
            cnt <= '0;
        else if (rvalid && rready && !rlast)
            cnt <= cnt + 8'd1;
    end
endmodule
